// File: rtl/sme_feeder.sv
`default_nettype none
// =====================================================================
// Module   : sme_feeder
// Brief    : Buffers one string/pattern job and replays it as the
//            engine's isstring/ispattern burst. Optional watchdog in
//            WAIT is enabled by defining SME_FEED_TIMEOUT_EN.
// Revision : 1.0
// =====================================================================
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TMO_CYC = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       busy,
  output logic       err,
  output logic       timeout
);

  localparam int MAXL = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int SIW  = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int PIW  = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam logic [CW-1:0] STR_LIM = CW'(STR_MAX);
  localparam logic [CW-1:0] PAT_LIM = CW'(PAT_MAX);
  localparam logic [CW-1:0] ONE     = CW'(1);

  if (TMO_CYC < 1 || TMO_CYC > 256) begin : g_tmo_range
    $error("sme_feeder: TMO_CYC must be in 1..256");
  end

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_EMIT_STR = 2'd1,
    S_EMIT_PAT = 2'd2,
    S_WAIT     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] str_cnt_q, str_cnt_d, str_len_q, str_len_d;
  logic [CW-1:0] pat_cnt_q, pat_cnt_d, pat_len_q, pat_len_d;
  logic [CW-1:0] rd_q, rd_d;
  logic          str_open_q, str_open_d;
  logic          new_str_q, new_str_d;
  logic          str_vld_q, str_vld_d;
  logic          err_q, err_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          isstring_q, isstring_d;
  logic          ispattern_q, ispattern_d;
  logic [7:0]    chardata_q, chardata_d;
  logic          acc;
  logic [CW-1:0] str_base;
  logic          str_we, pat_we;
  logic [CW-1:0] str_wa, pat_wa;
  logic [7:0]    str_buf_q [STR_MAX];
  logic [7:0]    pat_buf_q [PAT_MAX];
`ifdef SME_FEED_TIMEOUT_EN
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    str_cnt_d  = str_cnt_q;
    str_len_d  = str_len_q;
    pat_cnt_d  = pat_cnt_q;
    pat_len_d  = pat_len_q;
    rd_d       = rd_q;
    str_open_d = str_open_q;
    new_str_d  = new_str_q;
    str_vld_d  = str_vld_q;
    err_d      = err_q;
    str_base   = '0;
    str_we     = 1'b0;
    str_wa     = '0;
    pat_we     = 1'b0;
    pat_wa     = '0;
    acc        = in_valid & in_ready_q & (state_q == S_LOAD);
`ifdef SME_FEED_TIMEOUT_EN
    tmo_cnt_d  = '0;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_LOAD: begin
        if (acc && !in_kind) begin
          // A string character abandons any half-received pattern
          if (pat_cnt_q != '0) begin
            pat_cnt_d = '0;
            err_d     = 1'b1;
          end
          str_base = str_open_q ? str_cnt_q : '0;
          if (str_base < STR_LIM) begin
            str_we    = 1'b1;
            str_wa    = str_base;
            str_cnt_d = str_base + ONE;
          end else begin
            err_d     = 1'b1;
            str_cnt_d = str_base;
          end
          str_len_d  = str_cnt_d;
          new_str_d  = 1'b1;
          str_open_d = !in_last;
          if (in_last) str_vld_d = 1'b1;
        end else if (acc) begin
          if (pat_cnt_q < PAT_LIM) begin
            pat_we    = 1'b1;
            pat_wa    = pat_cnt_q;
            pat_cnt_d = pat_cnt_q + ONE;
          end else begin
            err_d     = 1'b1;
          end
          if (in_last) begin
            pat_len_d  = pat_cnt_d;
            pat_cnt_d  = '0;
            str_open_d = 1'b0;
            rd_d       = '0;
            if (new_str_q) begin
              state_d   = S_EMIT_STR;
              new_str_d = 1'b0;
            end else if (str_vld_q) begin
              state_d   = S_EMIT_PAT;
            end else begin
              err_d     = 1'b1;
            end
          end
        end
      end
      S_EMIT_STR: begin
        if (rd_q == str_len_q - ONE) begin
          state_d = S_EMIT_PAT;
          rd_d    = '0;
        end else begin
          rd_d    = rd_q + ONE;
        end
      end
      S_EMIT_PAT: begin
        if (rd_q == pat_len_q - ONE) begin
          state_d = S_WAIT;
          rd_d    = '0;
        end else begin
          rd_d    = rd_q + ONE;
        end
      end
      S_WAIT: begin
        if (sme_valid) begin
          state_d = S_LOAD;
`ifdef SME_FEED_TIMEOUT_EN
        end else if (tmo_cnt_q == 8'(TMO_CYC - 1)) begin
          state_d   = S_LOAD;
          timeout_d = 1'b1;
          str_vld_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = S_LOAD;
    endcase

    // Outputs are registered from the next state so the burst starts one cycle after the closing edge
    in_ready_d  = (state_d == S_LOAD);
    busy_d      = (state_d != S_LOAD);
    isstring_d  = (state_d == S_EMIT_STR);
    ispattern_d = (state_d == S_EMIT_PAT);
    chardata_d  = 8'h00;
    if (state_d == S_EMIT_STR) begin
      chardata_d = str_buf_q[rd_d[SIW-1:0]];
    end else if (state_d == S_EMIT_PAT) begin
      chardata_d = (pat_we && pat_wa == rd_d) ? in_data : pat_buf_q[rd_d[PIW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (str_we) str_buf_q[str_wa[SIW-1:0]] <= in_data;
    if (pat_we) pat_buf_q[pat_wa[PIW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      str_cnt_q   <= '0;
      str_len_q   <= '0;
      pat_cnt_q   <= '0;
      pat_len_q   <= '0;
      rd_q        <= '0;
      str_open_q  <= 1'b0;
      new_str_q   <= 1'b0;
      str_vld_q   <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      chardata_q  <= 8'h00;
`ifdef SME_FEED_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      str_cnt_q   <= str_cnt_d;
      str_len_q   <= str_len_d;
      pat_cnt_q   <= pat_cnt_d;
      pat_len_q   <= pat_len_d;
      rd_q        <= rd_d;
      str_open_q  <= str_open_d;
      new_str_q   <= new_str_d;
      str_vld_q   <= str_vld_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      chardata_q  <= chardata_d;
`ifdef SME_FEED_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign chardata  = chardata_q;
  assign err       = err_q;
`ifdef SME_FEED_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sme_feeder.md
# sme_feeder

Upstream framing stage for the string-matching engine. Accepts a byte stream of string and pattern characters over a valid/ready handshake, buffers one complete job (optional new string plus one pattern), and replays it as the engine's `chardata`/`isstring`/`ispattern` burst protocol. Holds off further input until the engine's `valid` pulse reports the result.

## Interface
Parameters:
- `STR_MAX`, 32: maximum string length in characters.
- `PAT_MAX`, 8: maximum pattern length in characters.
- `TMO_CYC`, 64: watchdog limit in cycles (used only with `SME_FEED_TIMEOUT_EN`).

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: input character valid.
- `in_ready`, out, 1: feeder accepts a character this cycle.
- `in_data`, in, 8: character byte.
- `in_kind`, in, 1: 0 = string character, 1 = pattern character.
- `in_last`, in, 1: last character of the current string or pattern.
- `chardata`, out, 8: character to the engine.
- `isstring`, out, 1: `chardata` is a string character.
- `ispattern`, out, 1: `chardata` is a pattern character.
- `sme_valid`, in, 1: engine result-valid pulse.
- `busy`, out, 1: high in every state except `LOAD`.
- `err`, out, 1: sticky; set on overflow or on a pattern with no string loaded since reset. Cleared only by reset.
- `timeout`, out, 1: one-cycle pulse on watchdog expiry. Tied 0 without the macro.

## Operation
- States:
  - `LOAD`: `in_ready` = 1. A transfer occurs when `in_valid & in_ready`.
    - Kind 0 writes `str_buf[str_wr]`. Kind 1 writes `pat_buf[pat_wr]`.
    - The first kind-0 transfer of a job clears `str_wr` and sets `new_str`.
  - `EMIT_STR`: drives `str_buf[0..str_len-1]` with `isstring` = 1, one character per cycle.
  - `EMIT_PAT`: drives `pat_buf[0..pat_len-1]` with `ispattern` = 1.
  - `WAIT`: idles until `sme_valid`.
- Transitions:
  - `LOAD` → `EMIT_STR` on the accepted kind-1 `in_last` when `new_str` = 1.
  - `LOAD` → `EMIT_PAT` on the same condition when `new_str` = 0 and a string has been loaded since reset.
  - `EMIT_STR` → `EMIT_PAT` after the last string character, with no gap cycle. The engine latches a garbage pattern byte if `isstring` falls without `ispattern` rising.
  - `EMIT_PAT` → `WAIT` after the last pattern character.
  - `WAIT` → `LOAD` on `sme_valid`.
- A kind-0 `in_last` only closes the string (`str_len` = `str_wr`+1). The state stays in `LOAD`.
- Once a string is loaded, it is retained. Later jobs that carry only a pattern reuse it and do not re-emit it; this matches the engine keeping its string across patterns.
- Overflow: characters beyond `STR_MAX`/`PAT_MAX` are dropped and set `err`. The length saturates at the maximum.
- Pattern with no string ever loaded: the pattern is discarded on `in_last`, `err` is set, and the state stays in `LOAD`.
- Kind switch from 1 to 0 mid-pattern: the pattern is discarded, `err` is set, and string loading proceeds.
- `chardata` = 0 whenever `isstring` and `ispattern` are both 0. `isstring` and `ispattern` are never 1 together.
- Reset mid-operation: FSM to `LOAD`, buffers invalidated (no string loaded), all counters 0.

## Timing
- All outputs are registered.
- Reset values: `in_ready` = 0 during reset and 1 from the first cycle after; `chardata` = 0, `isstring` = 0, `ispattern` = 0, `busy` = 0, `err` = 0, `timeout` = 0.
- Latency: the first `isstring` (or `ispattern`) is asserted on the cycle after the edge accepting the pattern's `in_last`.
- A burst lasts `str_len + pat_len` consecutive cycles.
- `in_ready` drops on the cycle after the accepted final `in_last`. It returns to 1 on the cycle after `sme_valid` is sampled high in `WAIT`.
- `sme_valid` outside `WAIT` is ignored.

## Configuration
- `SME_FEED_TIMEOUT_EN` defined: an 8-bit cycle counter runs in `WAIT`.
  - When it reaches `TMO_CYC` with no `sme_valid`, `timeout` pulses for one cycle and the FSM returns to `LOAD`.
  - The retained string is marked invalid, so the next job must resend a string.
- Not defined: no counter; `WAIT` holds indefinitely and `timeout` is constant 0.

## Test plan
- String "ABCD" (kind 0, last on 'D') then pattern "BC" (last on 'C'): `isstring` high for 4 cycles with A,B,C,D, then immediately `ispattern` for 2 cycles with B,C, then `busy` = 1 until `sme_valid`.
- After the previous case, pattern "^A" only: no `isstring`; `ispattern` for 2 cycles with '^','A'; the string is not resent.
- Pattern "XY" sent after reset with no string: no output burst, `err` = 1, `in_ready` stays 1.
- 34-character string: 32 characters emitted, `err` = 1, burst length 32 + `pat_len`.
- `in_valid` held during `WAIT`: `in_ready` = 0 and no transfers until the cycle after `sme_valid`.
- With `SME_FEED_TIMEOUT_EN`, no `sme_valid`: `timeout` pulses 64 cycles after entering `WAIT`, the FSM returns to `LOAD`, and a following pattern-only job sets `err`.
